// File: rtl/bsg_axi_burst_master.sv
// Command-driven AXI4 burst master: one fixed-length write (AW->W->B) or
// read (AR->R) burst outstanding at a time, with per-transaction status.
module bsg_axi_burst_master #(
    parameter int unsigned axi_id_width_p   = 4,
    parameter int unsigned axi_addr_width_p = 32,
    parameter int unsigned axi_data_width_p = 64,
    parameter int unsigned axi_burst_len_p  = 4,
    parameter logic [1:0]  axi_burst_type_p = 2'b01
) (
    input  logic                          clk_i,
    input  logic                          reset_i,

    // command
    input  logic                          cmd_v_i,
    input  logic                          cmd_w_i,
    input  logic [axi_addr_width_p-1:0]   cmd_addr_i,
    output logic                          cmd_ready_o,

    // write beats
    input  logic                          wdata_v_i,
    input  logic [axi_data_width_p-1:0]   wdata_i,
    output logic                          wdata_ready_o,

    // read beats
    output logic                          rdata_v_o,
    output logic [axi_data_width_p-1:0]   rdata_o,
    output logic                          rdata_last_o,
    input  logic                          rdata_ready_i,

    // completion
    output logic                          done_v_o,
    output logic                          done_err_o,

    // AW
    output logic [axi_id_width_p-1:0]     axi_awid_o,
    output logic [axi_addr_width_p-1:0]   axi_awaddr_o,
    output logic [7:0]                    axi_awlen_o,
    output logic [2:0]                    axi_awsize_o,
    output logic [1:0]                    axi_awburst_o,
    output logic                          axi_awvalid_o,
    input  logic                          axi_awready_i,

    // W
    output logic [axi_data_width_p-1:0]   axi_wdata_o,
    output logic [axi_data_width_p/8-1:0] axi_wstrb_o,
    output logic                          axi_wlast_o,
    output logic                          axi_wvalid_o,
    input  logic                          axi_wready_i,

    // B
    input  logic [axi_id_width_p-1:0]     axi_bid_i,
    input  logic [1:0]                    axi_bresp_i,
    input  logic                          axi_bvalid_i,
    output logic                          axi_bready_o,

    // AR
    output logic [axi_id_width_p-1:0]     axi_arid_o,
    output logic [axi_addr_width_p-1:0]   axi_araddr_o,
    output logic [7:0]                    axi_arlen_o,
    output logic [2:0]                    axi_arsize_o,
    output logic [1:0]                    axi_arburst_o,
    output logic                          axi_arvalid_o,
    input  logic                          axi_arready_i,

    // R
    input  logic [axi_id_width_p-1:0]     axi_rid_i,
    input  logic [axi_data_width_p-1:0]   axi_rdata_i,
    input  logic [1:0]                    axi_rresp_i,
    input  logic                          axi_rlast_i,
    input  logic                          axi_rvalid_i,
    output logic                          axi_rready_o
);

    // a one-beat burst still needs a 1-bit counter so the compare is legal
    localparam int unsigned beat_width_lp = (axi_burst_len_p > 1) ? $clog2(axi_burst_len_p) : 1;
    localparam int unsigned strb_width_lp = axi_data_width_p / 8;
    localparam logic [beat_width_lp-1:0] last_beat_lp = beat_width_lp'(axi_burst_len_p - 1);
    localparam logic [7:0] axlen_lp  = 8'(axi_burst_len_p - 1);
    localparam logic [2:0] axsize_lp = 3'($clog2(strb_width_lp));

    typedef enum logic [2:0] {
        e_idle, e_wr_addr, e_wr_data, e_wr_resp, e_rd_addr, e_rd_data, e_done
    } state_e;

    state_e                        state_r, state_n;
    logic [axi_addr_width_p-1:0]   addr_r, addr_n;
    logic [axi_id_width_p-1:0]     id_r;
    logic [beat_width_lp-1:0]      beat_r, beat_n;
    logic                          err_r, err_n;
    logic                          last_beat;

    assign last_beat = (beat_r == last_beat_lp);

    // state, latched command and transaction bookkeeping
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_idle;
            addr_r  <= '0;
            id_r    <= '0;
            beat_r  <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            addr_r  <= addr_n;
            beat_r  <= beat_n;
            err_r   <= err_n;
            // ID advances once per completed transaction, wrapping naturally
            if (state_r == e_done)
                id_r <= id_r + axi_id_width_p'(1);
        end
    end

    // next state and all channel outputs
    always_comb begin
        state_n = state_r;
        addr_n  = addr_r;
        beat_n  = beat_r;
        err_n   = err_r;

        cmd_ready_o   = 1'b0;
        wdata_ready_o = 1'b0;
        rdata_v_o     = 1'b0;
        rdata_o       = '0;
        rdata_last_o  = 1'b0;
        done_v_o      = 1'b0;
        done_err_o    = 1'b0;

        axi_awid_o    = id_r;
        axi_awaddr_o  = addr_r;
        axi_awlen_o   = axlen_lp;
        axi_awsize_o  = axsize_lp;
        axi_awburst_o = axi_burst_type_p;
        axi_awvalid_o = 1'b0;

        axi_wdata_o   = '0;
        axi_wstrb_o   = '1;
        axi_wlast_o   = 1'b0;
        axi_wvalid_o  = 1'b0;

        axi_bready_o  = 1'b0;

        axi_arid_o    = id_r;
        axi_araddr_o  = addr_r;
        axi_arlen_o   = axlen_lp;
        axi_arsize_o  = axsize_lp;
        axi_arburst_o = axi_burst_type_p;
        axi_arvalid_o = 1'b0;

        axi_rready_o  = 1'b0;

        case (state_r)
            e_idle: begin
                cmd_ready_o = 1'b1;
                if (cmd_v_i) begin
                    addr_n  = cmd_addr_i;
                    err_n   = 1'b0;
                    beat_n  = '0;
                    state_n = cmd_w_i ? e_wr_addr : e_rd_addr;
                end
            end

            e_wr_addr: begin
                axi_awvalid_o = 1'b1;
                if (axi_awready_i)
                    state_n = e_wr_data;
            end

            // zero-latency pass-through between the beat port and the W channel
            e_wr_data: begin
                axi_wvalid_o  = wdata_v_i;
                axi_wdata_o   = wdata_i;
                axi_wlast_o   = last_beat;
                wdata_ready_o = axi_wready_i;
                if (wdata_v_i && axi_wready_i) begin
                    beat_n = beat_r + beat_width_lp'(1);
                    if (last_beat)
                        state_n = e_wr_resp;
                end
            end

            e_wr_resp: begin
                axi_bready_o = 1'b1;
                if (axi_bvalid_i) begin
                    err_n   = err_r | (axi_bresp_i != 2'b00) | (axi_bid_i != id_r);
                    state_n = e_done;
                end
            end

            e_rd_addr: begin
                axi_arvalid_o = 1'b1;
                if (axi_arready_i)
                    state_n = e_rd_data;
            end

            // burst length is trusted from our own count; a misplaced rlast is only flagged
            e_rd_data: begin
                rdata_v_o    = axi_rvalid_i;
                rdata_o      = axi_rdata_i;
                rdata_last_o = last_beat;
                axi_rready_o = rdata_ready_i;
                if (axi_rvalid_i && rdata_ready_i) begin
                    beat_n = beat_r + beat_width_lp'(1);
                    err_n  = err_r | (axi_rresp_i != 2'b00) | (axi_rid_i != id_r)
                           | (axi_rlast_i != last_beat);
                    if (last_beat)
                        state_n = e_done;
                end
            end

            e_done: begin
                done_v_o   = 1'b1;
                done_err_o = err_r;
                state_n    = e_idle;
            end

            default: state_n = e_idle;
        endcase
    end

endmodule

// File: tb/tb_bsg_axi_burst_master.sv
// Directed bench: the bench plays both the command/beat source and a small
// wrapping AXI memory, checking every channel handshake cycle by cycle.
module tb_bsg_axi_burst_master;

    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int LEN = 4;
    localparam logic [1:0] BT = 2'b10;   // WRAP, so the memory wraps within 32 bytes

    logic clk_i = 1'b0;
    logic reset_i;

    logic cmd_v_i, cmd_w_i, cmd_ready_o;
    logic [AW-1:0] cmd_addr_i;
    logic wdata_v_i, wdata_ready_o;
    logic [DW-1:0] wdata_i;
    logic rdata_v_o, rdata_last_o, rdata_ready_i;
    logic [DW-1:0] rdata_o;
    logic done_v_o, done_err_o;

    logic [IDW-1:0] axi_awid_o, axi_arid_o, axi_bid_i, axi_rid_i;
    logic [AW-1:0]  axi_awaddr_o, axi_araddr_o;
    logic [7:0]     axi_awlen_o, axi_arlen_o;
    logic [2:0]     axi_awsize_o, axi_arsize_o;
    logic [1:0]     axi_awburst_o, axi_arburst_o, axi_bresp_i, axi_rresp_i;
    logic axi_awvalid_o, axi_awready_i, axi_arvalid_o, axi_arready_i;
    logic [DW-1:0]  axi_wdata_o, axi_rdata_i;
    logic [DW/8-1:0] axi_wstrb_o;
    logic axi_wlast_o, axi_wvalid_o, axi_wready_i;
    logic axi_bvalid_i, axi_bready_o;
    logic axi_rlast_i, axi_rvalid_i, axi_rready_o;

    always #5 clk_i = ~clk_i;

    bsg_axi_burst_master #(
        .axi_id_width_p(IDW), .axi_addr_width_p(AW), .axi_data_width_p(DW),
        .axi_burst_len_p(LEN), .axi_burst_type_p(BT)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cmd_v_i(cmd_v_i), .cmd_w_i(cmd_w_i), .cmd_addr_i(cmd_addr_i), .cmd_ready_o(cmd_ready_o),
        .wdata_v_i(wdata_v_i), .wdata_i(wdata_i), .wdata_ready_o(wdata_ready_o),
        .rdata_v_o(rdata_v_o), .rdata_o(rdata_o), .rdata_last_o(rdata_last_o), .rdata_ready_i(rdata_ready_i),
        .done_v_o(done_v_o), .done_err_o(done_err_o),
        .axi_awid_o(axi_awid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awlen_o(axi_awlen_o),
        .axi_awsize_o(axi_awsize_o), .axi_awburst_o(axi_awburst_o), .axi_awvalid_o(axi_awvalid_o),
        .axi_awready_i(axi_awready_i),
        .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o), .axi_wlast_o(axi_wlast_o),
        .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
        .axi_bid_i(axi_bid_i), .axi_bresp_i(axi_bresp_i), .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o),
        .axi_arid_o(axi_arid_o), .axi_araddr_o(axi_araddr_o), .axi_arlen_o(axi_arlen_o),
        .axi_arsize_o(axi_arsize_o), .axi_arburst_o(axi_arburst_o), .axi_arvalid_o(axi_arvalid_o),
        .axi_arready_i(axi_arready_i),
        .axi_rid_i(axi_rid_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i), .axi_rlast_i(axi_rlast_i),
        .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0]  mem [logic [AW-1:0]];
    logic [IDW-1:0] exp_id = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    // wrapping beat address for a 4 x 8-byte burst
    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a, input int k);
        logic [AW-1:0] lin;
        logic [AW-1:0] msk;
        lin = a + AW'(k * 8);
        msk = AW'(LEN * 8 - 1);
        return (a & ~msk) | (lin & msk);
    endfunction

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    task automatic idle_inputs();
        cmd_v_i = 0; cmd_w_i = 0; cmd_addr_i = '0;
        wdata_v_i = 0; wdata_i = '0; rdata_ready_i = 0;
        axi_awready_i = 0; axi_wready_i = 0;
        axi_bid_i = '0; axi_bresp_i = '0; axi_bvalid_i = 0;
        axi_arready_i = 0;
        axi_rid_i = '0; axi_rdata_i = '0; axi_rresp_i = '0; axi_rlast_i = 0; axi_rvalid_i = 0;
    endtask

    task automatic write_burst(input logic [AW-1:0] a, input logic [LEN-1:0][DW-1:0] d,
                               input int aw_delay, input logic [7:0] gap,
                               input logic [1:0] resp, input logic exp_err, input int abort_at);
        int cyc = 0, wait_aw = 0, wb = 0;
        bit accepted = 0, aw_ok = 0, b_ok = 0, fin = 0;
        logic [IDW-1:0] cap_id = '0;
        @(negedge clk_i);
        while (!fin && cyc < 200) begin
            cmd_v_i = !accepted; cmd_w_i = 1; cmd_addr_i = a;
            axi_awready_i = !aw_ok && (wait_aw >= aw_delay);
            wdata_v_i = (wb < LEN) && !gap[cyc % 8];
            wdata_i   = (wb < LEN) ? d[wb] : '0;
            axi_wready_i = 1;
            axi_bvalid_i = (wb == LEN) && !b_ok; axi_bresp_i = resp; axi_bid_i = cap_id;
            #1;
            if (cmd_v_i && cmd_ready_o) accepted = 1;
            if (!aw_ok && accepted && wb == 0) chk("wr_early_ready", 64'(wdata_ready_o && axi_awvalid_o), 64'(0));
            if (axi_awvalid_o) begin
                chk("awaddr", 64'(axi_awaddr_o), 64'(a));
                chk("awid", 64'(axi_awid_o), 64'(exp_id));
                chk("awlen", 64'(axi_awlen_o), 64'(LEN - 1));
                chk("awsize", 64'(axi_awsize_o), 64'(3));
                chk("awburst", 64'(axi_awburst_o), 64'(BT));
                if (axi_awready_i) begin aw_ok = 1; cap_id = axi_awid_o; end
                else wait_aw++;
            end
            if (wdata_v_i && wdata_ready_o) begin
                chk("wvalid", 64'(axi_wvalid_o), 64'(1));
                chk("wdata", 64'(axi_wdata_o), 64'(d[wb]));
                chk("wlast", 64'(axi_wlast_o), 64'(wb == LEN - 1));
                chk("wstrb", 64'(axi_wstrb_o), 64'(8'hff));
                mem[beat_addr(a, wb)] = axi_wdata_o;
                wb++;
            end
            if (axi_bvalid_i && axi_bready_o) b_ok = 1;
            if (done_v_o) begin
                chk("wr_done_err", 64'(done_err_o), 64'(exp_err));
                chk("wr_done_cmd_ready", 64'(cmd_ready_o), 64'(0));
                exp_id++;
                fin = 1;
            end
            if (abort_at > 0 && wb == abort_at) begin
                // let the pending handshake land before the caller resets
                @(negedge clk_i);
                fin = 1;
            end
            if (!fin) begin
                @(negedge clk_i);
                cyc++;
            end
        end
        idle_inputs();
        if (!fin) chk("wr_timeout", 64'(0), 64'(1));
        else if (abort_at == 0) begin
            @(negedge clk_i); #1;
            chk("wr_done_once", 64'(done_v_o), 64'(0));
            chk("wr_idle_ready", 64'(cmd_ready_o), 64'(1));
        end
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input logic [LEN-1:0][DW-1:0] e,
                              input int rlow, input int bad_last, input logic exp_err);
        int cyc = 0, rb = 0, lowcnt = 0;
        bit accepted = 0, ar_ok = 0, fin = 0;
        logic [IDW-1:0] cap_id = '0;
        @(negedge clk_i);
        while (!fin && cyc < 200) begin
            cmd_v_i = !accepted; cmd_w_i = 0; cmd_addr_i = a;
            axi_arready_i = !ar_ok;
            axi_rvalid_i  = ar_ok && (rb < LEN);
            axi_rdata_i   = mem_rd(beat_addr(a, rb));
            axi_rid_i     = cap_id; axi_rresp_i = 2'b00;
            axi_rlast_i   = (rb == LEN - 1) || (rb == bad_last);
            rdata_ready_i = !(axi_rvalid_i && lowcnt < rlow);
            #1;
            if (cmd_v_i && cmd_ready_o) accepted = 1;
            if (axi_arvalid_o) begin
                chk("araddr", 64'(axi_araddr_o), 64'(a));
                chk("arid", 64'(axi_arid_o), 64'(exp_id));
                chk("arlen", 64'(axi_arlen_o), 64'(LEN - 1));
                chk("arsize", 64'(axi_arsize_o), 64'(3));
                chk("arburst", 64'(axi_arburst_o), 64'(BT));
                if (axi_arready_i) begin ar_ok = 1; cap_id = axi_arid_o; end
            end
            if (axi_rvalid_i) begin
                chk("rdata_v", 64'(rdata_v_o), 64'(1));
                chk("rready", 64'(axi_rready_o), 64'(rdata_ready_i));
                if (!rdata_ready_i) lowcnt++;
            end
            if (rdata_v_o && rdata_ready_i && rb < LEN) begin
                chk("rdata", 64'(rdata_o), 64'(e[rb]));
                chk("rdata_last", 64'(rdata_last_o), 64'(rb == LEN - 1));
                rb++;
            end
            if (done_v_o) begin
                chk("rd_done_err", 64'(done_err_o), 64'(exp_err));
                chk("rd_beats", 64'(rb), 64'(LEN));
                exp_id++;
                fin = 1;
            end
            if (!fin) begin
                @(negedge clk_i);
                cyc++;
            end
        end
        idle_inputs();
        if (!fin) chk("rd_timeout", 64'(0), 64'(1));
        else begin
            @(negedge clk_i); #1;
            chk("rd_done_once", 64'(done_v_o), 64'(0));
        end
    endtask

    initial begin
        logic [LEN-1:0][DW-1:0] v;
        idle_inputs();
        reset_i = 1;
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready_o), 64'(1));
        chk("rst_awvalid", 64'(axi_awvalid_o), 64'(0));
        chk("rst_arvalid", 64'(axi_arvalid_o), 64'(0));
        chk("rst_done", 64'(done_v_o), 64'(0));
        chk("rst_bready", 64'(axi_bready_o), 64'(0));
        chk("rst_rready", 64'(axi_rready_o), 64'(0));
        reset_i = 0;

        // basic write then read back
        v = {64'd4, 64'd3, 64'd2, 64'd1};
        write_burst(32'h100, v, 0, 8'h00, 2'b00, 1'b0, 0);
        read_burst(32'h100, v, 0, -1, 1'b0);

        // slow AW, gappy write data, stalled read consumer
        v = {64'h44, 64'h33, 64'h22, 64'h11};
        write_burst(32'h200, v, 5, 8'b1010_0100, 2'b00, 1'b0, 0);
        read_burst(32'h200, v, 3, -1, 1'b0);

        // wrapping read starting mid-line
        v = {64'hDDDD, 64'hCCCC, 64'hBBBB, 64'hAAAA};
        write_burst(32'h100, v, 0, 8'h00, 2'b00, 1'b0, 0);
        v = {64'hAAAA, 64'hDDDD, 64'hCCCC, 64'hBBBB};
        read_burst(32'h108, v, 0, -1, 1'b0);

        // slave error on write response; following read is clean
        v = {64'h3004, 64'h3003, 64'h3002, 64'h3001};
        write_burst(32'h300, v, 1, 8'h00, 2'b10, 1'b1, 0);
        read_burst(32'h300, v, 0, -1, 1'b0);

        // early rlast on beat 2: flagged, burst still runs four beats
        v = {64'hDDDD, 64'hCCCC, 64'hBBBB, 64'hAAAA};
        read_burst(32'h100, v, 0, 1, 1'b1);

        // reset partway through a write burst
        v = {64'h4004, 64'h4003, 64'h4002, 64'h4001};
        write_burst(32'h400, v, 0, 8'h00, 2'b00, 1'b0, 2);
        reset_i = 1;
        @(negedge clk_i);
        reset_i = 0;
        exp_id = '0;
        #1;
        chk("abort_cmd_ready", 64'(cmd_ready_o), 64'(1));
        chk("abort_wready", 64'(wdata_ready_o), 64'(0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i); #1;
            chk("abort_no_done", 64'(done_v_o), 64'(0));
        end
        v = {64'hAAAA, 64'hDDDD, 64'hCCCC, 64'hBBBB};
        read_burst(32'h108, v, 0, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
